// File: rtl/maxpool2x2_unit_if.sv
// Stream/handshake bundle for maxpool2x2_unit: layer control, beat input, pooled output.
interface maxpool2x2_unit_if #(
    parameter int DATA_WIDTH       = 16,
    parameter int POOL_PARALLELISM = 8
);
    localparam int DW = DATA_WIDTH;
    localparam int PP = POOL_PARALLELISM;

    logic                   en;
    logic [7:0]             input_size;
    logic [7:0]             channel;
    logic [2*DW*PP-1:0]     infeature;
    logic [7:0]             inw;
    logic [7:0]             channel_sel;
    logic                   channel_done;
    logic [DW*PP-1:0]       outfeature;
    logic                   out_valid;
    logic [7:0]             outh;
    logic [7:0]             outw;
    logic                   done;

    modport master (
        output en, input_size, channel, infeature,
        input  inw, channel_sel, channel_done, outfeature, out_valid, outh, outw, done
    );

    modport slave (
        input  en, input_size, channel, infeature,
        output inw, channel_sel, channel_done, outfeature, out_valid, outh, outw, done
    );
endinterface

// File: rtl/maxpool2x2_unit.sv
// 2x2/stride-2 max-pool engine: even rows park 1x2 maxima in a row buffer, odd rows merge.
// Optional fused ReLU on the pooled result when POOL_RELU_EN is defined.
module maxpool2x2_lane #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    input  logic signed [DW-1:0] buf_i,
    input  logic signed [DW-1:0] m1_q_i,
    output logic signed [DW-1:0] m1_o,
    output logic signed [DW-1:0] res_o
);
    logic signed [DW-1:0] mx;

    assign m1_o = (a_i > b_i) ? a_i : b_i;
    assign mx   = (buf_i > m1_q_i) ? buf_i : m1_q_i;
`ifdef POOL_RELU_EN
    assign res_o = mx[DW-1] ? '0 : mx;
`else
    assign res_o = mx;
`endif
endmodule

module maxpool2x2_unit #(
    parameter int DATA_WIDTH       = 16,
    parameter int POOL_PARALLELISM = 8,
    parameter int MAX_GROUPS       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    maxpool2x2_unit_if.slave       bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int PP    = POOL_PARALLELISM;
    localparam int DEPTH = 16 * MAX_GROUPS;
    localparam int AW    = $clog2(DEPTH);

    logic                    busy_q, busy_d;
    logic                    inh_q, inh_d;
    logic [7:0]              inw_q, inw_d;
    logic [7:0]              cs_q, cs_d;
    logic [7:0]              outh_q, outh_d;
    logic [7:0]              h_q, h_d;
    logic [7:0]              c_q, c_d;

    logic [PP-1:0][DW-1:0]   m1, res;
    logic [PP-1:0][DW-1:0]   m1_q, rd_q, of_q;
    logic [7:0]              oh1_q, ow1_q, oh_q, ow_q;
    logic [2:1]              vld_pipe_q, last_pipe_q;
    logic                    done_q;

    logic [PP-1:0][DW-1:0]   mem [DEPTH];

    logic [7:0]              half, half_m1;
    logic                    last_col, last_row, chan_done;
    logic                    beat_odd, beat_last, start;
    logic [AW-1:0]           addr;

    assign half      = h_q >> 1;
    assign half_m1   = half - 8'd1;
    assign last_col  = (inw_q == half_m1);
    assign last_row  = (outh_q == half_m1);
    assign chan_done = ({1'b0, cs_q} + 9'(PP)) >= {1'b0, c_q};
    assign beat_odd  = busy_q & inh_q;
    assign beat_last = beat_odd & last_col & last_row & chan_done;
    assign start     = ~busy_q & bus.en & (bus.input_size >= 8'd2) & (bus.channel != 8'd0);
    assign addr      = AW'(inw_q) * AW'(MAX_GROUPS) + AW'(cs_q / 8'(PP));

    genvar j;
    generate
        for (j = 0; j < PP; j++) begin : g_lane
            maxpool2x2_lane #(.DW(DW)) u_lane (
                .a_i    (bus.infeature[2*DW*j +: DW]),
                .b_i    (bus.infeature[2*DW*j+DW +: DW]),
                .buf_i  (rd_q[j]),
                .m1_q_i (m1_q[j]),
                .m1_o   (m1[j]),
                .res_o  (res[j])
            );
        end
    endgenerate

    // Channel group is the fastest index, then column, then row parity, then output row.
    always_comb begin
        busy_d = busy_q;
        inh_d  = inh_q;
        inw_d  = inw_q;
        cs_d   = cs_q;
        outh_d = outh_q;
        h_d    = h_q;
        c_d    = c_q;
        if (start) begin
            busy_d = 1'b1;
            inh_d  = 1'b0;
            inw_d  = 8'd0;
            cs_d   = 8'd0;
            outh_d = 8'd0;
            h_d    = bus.input_size;
            c_d    = bus.channel;
        end else if (busy_q) begin
            if (chan_done) begin
                cs_d = 8'd0;
                if (last_col) begin
                    inw_d = 8'd0;
                    inh_d = ~inh_q;
                    if (inh_q) outh_d = outh_q + 8'd1;
                end else begin
                    inw_d = inw_q + 8'd1;
                end
            end else begin
                cs_d = cs_q + 8'(PP);
            end
            if (beat_last) begin
                busy_d = 1'b0;
                outh_d = 8'd0;
            end
        end
    end

    // Even and odd rows never overlap in time, so write and read addresses cannot collide.
    always_ff @(posedge clk) begin
        if (busy_q && !inh_q) mem[addr] <= m1;
        if (beat_odd)         rd_q      <= mem[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            inh_q       <= 1'b0;
            inw_q       <= 8'd0;
            cs_q        <= 8'd0;
            outh_q      <= 8'd0;
            h_q         <= 8'd0;
            c_q         <= 8'd0;
            m1_q        <= '0;
            oh1_q       <= 8'd0;
            ow1_q       <= 8'd0;
            of_q        <= '0;
            oh_q        <= 8'd0;
            ow_q        <= 8'd0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            done_q      <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            inh_q       <= inh_d;
            inw_q       <= inw_d;
            cs_q        <= cs_d;
            outh_q      <= outh_d;
            h_q         <= h_d;
            c_q         <= c_d;
            vld_pipe_q  <= {vld_pipe_q[1], beat_odd};
            last_pipe_q <= {last_pipe_q[1], beat_last};
            if (beat_odd) begin
                m1_q  <= m1;
                oh1_q <= outh_q;
                ow1_q <= inw_q;
            end
            if (vld_pipe_q[1]) begin
                of_q <= res;
                oh_q <= oh1_q;
                ow_q <= ow1_q;
            end
            done_q <= vld_pipe_q[2] & last_pipe_q[2];
        end
    end

    assign bus.inw          = inw_q;
    assign bus.channel_sel  = cs_q;
    assign bus.channel_done = chan_done;
    assign bus.outfeature   = of_q;
    assign bus.out_valid    = vld_pipe_q[2];
    assign bus.outh         = oh_q;
    assign bus.outw         = ow_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_maxpool2x2_unit.sv
// Scoreboard bench for maxpool2x2_unit: stimulus pushes expected pooled results, a monitor pops them.
module tb_maxpool2x2_unit;
    localparam int DW = 16;
    localparam int PP = 8;
    localparam int MG = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool2x2_unit_if #(.DATA_WIDTH(DW), .POOL_PARALLELISM(PP)) bus();

    maxpool2x2_unit #(.DATA_WIDTH(DW), .POOL_PARALLELISM(PP), .MAX_GROUPS(MG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [PP-1:0][DW-1:0] f;
        int                    nch;
        int                    h;
        int                    w;
        logic                  last;
        int                    cyc;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   vld_cnt   = 0;
    int   done_cnt  = 0;
    logic prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every out_valid must match the oldest pending expectation, including latency.
    always @(negedge clk) begin
        exp_t e;
        logic exp_done;
        exp_done  = prev_last;
        prev_last = 1'b0;
        if (!rst) begin
            if (bus.out_valid) begin
                vld_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("outh", int'(bus.outh), e.h);
                    chk("outw", int'(bus.outw), e.w);
                    chk("latency_cycle", cyc, e.cyc);
                    for (int j = 0; j < e.nch; j++)
                        chk($sformatf("lane%0d_h%0d_w%0d", j, e.h, e.w),
                            int'($signed(bus.outfeature[DW*j +: DW])), int'($signed(e.f[j])));
                    prev_last = e.last;
                end
            end
            if (bus.done || exp_done) chk("done_timing", int'(bus.done), int'(exp_done));
            if (bus.done) done_cnt++;
        end
    end

    function automatic logic [DW-1:0] elem(input int mode, input int row, input int col, input int ch);
        if (mode == 0) return DW'(16 * row + col + 256 * ch);
        if (row % 2 == 0) return (col % 2 == 0) ? DW'(-5) : DW'(-3);
        return (col % 2 == 0) ? DW'(-7) : DW'(-1);
    endfunction

    // Hand-derived pooled value: ramp max sits at the bottom-right element of each window.
    function automatic int exp_val(input int mode, input int oh, input int ow, input int ch);
        if (mode == 0) return 16 * (2 * oh + 1) + (2 * ow + 1) + 256 * ch;
`ifdef POOL_RELU_EN
        return 0;
`else
        return -1;
`endif
    endfunction

    task automatic chk_zero_state(input string tag);
        chk({tag, "_out_valid"},  int'(bus.out_valid), 0);
        chk({tag, "_outfeature"}, int'(bus.outfeature != '0), 0);
        chk({tag, "_inw"},        int'(bus.inw), 0);
        chk({tag, "_channel_sel"},int'(bus.channel_sel), 0);
        chk({tag, "_outh"},       int'(bus.outh), 0);
        chk({tag, "_outw"},       int'(bus.outw), 0);
        chk({tag, "_done"},       int'(bus.done), 0);
    endtask

    task automatic run_layer(input int H, input int C, input int mode,
                             input int abort_beat, input int mid_en_beat, input int exp_outs);
        int half;
        int beat;
        int nch;
        logic [2*DW*PP-1:0] v;
        exp_t e;
        half     = H / 2;
        beat     = 0;
        vld_cnt  = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.en         = 1'b1;
        bus.input_size = 8'(H);
        bus.channel    = 8'(C);
        @(negedge clk);
        bus.en = 1'b0;
        for (int oh = 0; oh < half; oh++)
            for (int ih = 0; ih < 2; ih++)
                for (int iw = 0; iw < half; iw++)
                    for (int cs = 0; cs < C; cs += PP) begin
                        if (beat == abort_beat) begin
                            rst = 1'b1;
                            @(negedge clk);
                            chk_zero_state("abort");
                            rst = 1'b0;
                            q.delete();
                            return;
                        end
                        chk("inw", int'(bus.inw), iw);
                        chk("channel_sel", int'(bus.channel_sel), cs);
                        chk("channel_done", int'(bus.channel_done), int'(cs + PP >= C));
                        for (int j = 0; j < PP; j++) begin
                            v[2*DW*j +: DW]      = elem(mode, 2*oh + ih, 2*iw,     cs + j);
                            v[2*DW*j + DW +: DW] = elem(mode, 2*oh + ih, 2*iw + 1, cs + j);
                        end
                        bus.infeature = v;
                        if (beat == mid_en_beat) begin
                            bus.en         = 1'b1;
                            bus.input_size = 8'd2;
                            bus.channel    = 8'd1;
                        end else begin
                            bus.en = 1'b0;
                        end
                        if (ih == 1) begin
                            nch = (C - cs < PP) ? C - cs : PP;
                            for (int j = 0; j < PP; j++)
                                e.f[j] = (j < nch) ? DW'(exp_val(mode, oh, iw, cs + j)) : '0;
                            e.nch  = nch;
                            e.h    = oh;
                            e.w    = iw;
                            e.last = (oh == half - 1) && (iw == half - 1) && (cs + PP >= C);
                            e.cyc  = cyc + 2;
                            q.push_back(e);
                        end
                        beat++;
                        @(negedge clk);
                    end
        bus.en = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("out_valid_count", vld_cnt, exp_outs);
        chk("done_count", done_cnt, 1);
        chk("idle_inw", int'(bus.inw), 0);
        chk("idle_channel_sel", int'(bus.channel_sel), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en         = 1'b0;
        bus.input_size = 8'd0;
        bus.channel    = 8'd0;
        bus.infeature  = '0;
        rst            = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_state("reset");
        rst = 1'b0;

        run_layer(4, 8, 0, -1, -1, 4);    // ramp: (0,0)=0x11 .. (1,1)=0x33
        run_layer(4, 20, 0, -1, -1, 12);  // three channel groups, partial last group
        run_layer(2, 8, 1, -1, -1, 1);    // negative data
        run_layer(5, 8, 0, -1, -1, 4);    // odd H: last row/col never requested
        run_layer(4, 8, 0, 3, -1, 0);     // reset in the middle of the first odd row
        run_layer(4, 8, 0, -1, -1, 4);    // restart from (0,0)
        run_layer(4, 8, 0, -1, 2, 4);     // en while busy is ignored

        vld_cnt  = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.en = 1'b1; bus.input_size = 8'd1; bus.channel = 8'd8;
        @(negedge clk);
        bus.en = 1'b1; bus.input_size = 8'd4; bus.channel = 8'd0;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (6) @(negedge clk);
        chk("ignored_en_out_valid", vld_cnt, 0);
        chk("ignored_en_done", done_cnt, 0);
        chk("ignored_en_inw", int'(bus.inw), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
